// File: rtl/side_info_nch_if.sv
// side_info_nch_if
//   Bundles the side-info byte stream and the decoded field bus of
//   side_info_nch into a single interface.
//   Parameter MAX_CH must match the MAX_CH of the attached side_info_nch.
//   Stream (master -> slave): frame_start, mode[1:0], axiid[7:0], axiiv
//   Fields (slave -> master): axiov, err, main_data_begin, private_bits,
//     scfsi[ch], and per [granule][channel]: part2_3_length, big_values,
//     global_gain, scalefac_compress, window_switching_flag, block_type,
//     mixed_block_flag, table_select[3], subblock_gain[3], region0_count,
//     region1_count, preflag, scalefac_scale, count1table_select.
interface side_info_nch_if #(
    parameter int unsigned MAX_CH = 2
);
    logic                               frame_start;
    logic [1:0]                         mode;
    logic [7:0]                         axiid;
    logic                               axiiv;

    logic                               axiov;
    logic                               err;
    logic [8:0]                         main_data_begin;
    logic [4:0]                         private_bits;
    logic [MAX_CH-1:0][3:0]             scfsi;
    logic [1:0][MAX_CH-1:0][11:0]       part2_3_length;
    logic [1:0][MAX_CH-1:0][8:0]        big_values;
    logic [1:0][MAX_CH-1:0][7:0]        global_gain;
    logic [1:0][MAX_CH-1:0][3:0]        scalefac_compress;
    logic [1:0][MAX_CH-1:0]             window_switching_flag;
    logic [1:0][MAX_CH-1:0][1:0]        block_type;
    logic [1:0][MAX_CH-1:0]             mixed_block_flag;
    logic [1:0][MAX_CH-1:0][2:0][4:0]   table_select;
    logic [1:0][MAX_CH-1:0][2:0][2:0]   subblock_gain;
    logic [1:0][MAX_CH-1:0][3:0]        region0_count;
    logic [1:0][MAX_CH-1:0][3:0]        region1_count;
    logic [1:0][MAX_CH-1:0]             preflag;
    logic [1:0][MAX_CH-1:0]             scalefac_scale;
    logic [1:0][MAX_CH-1:0]             count1table_select;

    modport master (
        output frame_start, mode, axiid, axiiv,
        input  axiov, err, main_data_begin, private_bits, scfsi,
               part2_3_length, big_values, global_gain, scalefac_compress,
               window_switching_flag, block_type, mixed_block_flag,
               table_select, subblock_gain, region0_count, region1_count,
               preflag, scalefac_scale, count1table_select
    );

    modport slave (
        input  frame_start, mode, axiid, axiiv,
        output axiov, err, main_data_begin, private_bits, scfsi,
               part2_3_length, big_values, global_gain, scalefac_compress,
               window_switching_flag, block_type, mixed_block_flag,
               table_select, subblock_gain, region0_count, region1_count,
               preflag, scalefac_scale, count1table_select
    );
endinterface

// File: rtl/side_info_nch.sv
// side_info_nch
//   MP3 Layer III side-info parser for 1 or 2 channels. Collects 17 (mono)
//   or 32 (stereo) side-info bytes, then decodes every field into registers
//   and pulses axiov for one cycle, one cycle after the final byte.
//   Ports:
//     clk  - system clock
//     rst  - synchronous, active-high reset
//     bus  - side_info_nch_if.slave: byte stream in, decoded fields out
//   Parameter MAX_CH: 1 = every frame parsed as mono, 2 = mono/stereo by mode.
//   Optional macro SIDE_INFO_CHECK_EN: when defined, err flags a record with
//   big_values > 288 or window_switching_flag=1 with block_type=0; when
//   undefined err is tied 0.
module side_info_nch #(
    parameter int unsigned MAX_CH = 2
) (
    input logic          clk,
    input logic          rst,
    side_info_nch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, DECODE} state_t;

    typedef struct packed {
        logic [11:0]      p23;
        logic [8:0]       bv;
        logic [7:0]       gg;
        logic [3:0]       sfc;
        logic             wsf;
        logic [1:0]       bt;
        logic             mixed;
        logic [2:0][4:0]  ts;
        logic [2:0][2:0]  sbg;
        logic [3:0]       r0;
        logic [3:0]       r1;
        logic             pre;
        logic             sfs;
        logic             c1t;
    } gr_t;

    // One 59-bit granule/channel record, first transmitted bit at r[58].
    function automatic gr_t decode_rec(input logic [58:0] r);
        gr_t d;
        logic short_blk;
        d = '0;
        d.p23 = r[58:47];
        d.bv  = r[46:38];
        d.gg  = r[37:30];
        d.sfc = r[29:26];
        d.wsf = r[25];
        if (r[25]) begin
            short_blk = (r[24:23] == 2'd2) && !r[22];
            d.bt     = r[24:23];
            d.mixed  = r[22];
            d.ts[0]  = r[21:17];
            d.ts[1]  = r[16:12];
            d.sbg[0] = r[11:9];
            d.sbg[1] = r[8:6];
            d.sbg[2] = r[5:3];
            d.r0     = short_blk ? 4'd8 : 4'd7;
            d.r1     = short_blk ? 4'd12 : 4'd13;
        end else begin
            d.ts[0] = r[24:20];
            d.ts[1] = r[19:15];
            d.ts[2] = r[14:10];
            d.r0    = r[9:6];
            d.r1    = {1'b0, r[5:3]};
        end
        d.pre = r[2];
        d.sfs = r[1];
        d.c1t = r[0];
        return d;
    endfunction

    state_t                  state;
    logic [5:0]              cnt;
    logic [255:0]            sr;
    logic                    two_q;

    logic                    first;
    logic                    take;
    logic                    two_now;
    logic [5:0]              cur_idx;
    logic                    last;
    logic [255:0]            next_sr;
    logic [255:0]            aligned;
    logic [8:0]              mdb_d;
    logic [4:0]              priv_d;
    logic [MAX_CH-1:0][3:0]  scfsi_d;
    gr_t                     rec_d [2][MAX_CH];

    always_comb begin
        // frame_start or an idle parser makes the incoming byte byte 0;
        // frame_start also overrides the drop of bytes during DECODE.
        first   = bus.frame_start || (state == IDLE);
        take    = bus.axiiv && (bus.frame_start || (state != DECODE));
        two_now = first ? ((bus.mode != 2'b11) && (MAX_CH > 1)) : two_q;
        cur_idx = first ? '0 : cnt;
        last    = take && (cur_idx == (two_now ? 6'd31 : 6'd16));
        next_sr = {sr[247:0], bus.axiid};
        // A mono frame fills only the low 136 bits; move its first bit to [255].
        aligned = two_now ? next_sr : (next_sr << 120);

        mdb_d   = aligned[255:247];
        priv_d  = two_now ? {2'b00, aligned[246:244]} : aligned[246:242];
        scfsi_d = '0;
        for (int unsigned c = 0; c < MAX_CH; c++) begin
            if (two_now) begin
                scfsi_d[c] = aligned[243 - 4 * c -: 4];
            end else if (c == 0) begin
                scfsi_d[c] = aligned[241:238];
            end
        end

        for (int unsigned g = 0; g < 2; g++) begin
            for (int unsigned c = 0; c < MAX_CH; c++) begin
                rec_d[g][c] = '0;
                if (two_now) begin
                    rec_d[g][c] = decode_rec(aligned[255 - (20 + 59 * (2 * g + c)) -: 59]);
                end else if (c == 0) begin
                    rec_d[g][c] = decode_rec(aligned[255 - (18 + 59 * g) -: 59]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            cnt                       <= '0;
            sr                        <= '0;
            two_q                     <= 1'b0;
            bus.axiov                 <= 1'b0;
            bus.main_data_begin       <= '0;
            bus.private_bits          <= '0;
            bus.scfsi                 <= '0;
            bus.part2_3_length        <= '0;
            bus.big_values            <= '0;
            bus.global_gain           <= '0;
            bus.scalefac_compress     <= '0;
            bus.window_switching_flag <= '0;
            bus.block_type            <= '0;
            bus.mixed_block_flag      <= '0;
            bus.table_select          <= '0;
            bus.subblock_gain         <= '0;
            bus.region0_count         <= '0;
            bus.region1_count         <= '0;
            bus.preflag               <= '0;
            bus.scalefac_scale        <= '0;
            bus.count1table_select    <= '0;
        end else begin
            bus.axiov <= 1'b0;
            if (take) begin
                sr <= next_sr;
                if (first) begin
                    two_q <= two_now;
                end
                if (last) begin
                    state               <= DECODE;
                    cnt                 <= '0;
                    bus.axiov           <= 1'b1;
                    bus.main_data_begin <= mdb_d;
                    bus.private_bits    <= priv_d;
                    bus.scfsi           <= scfsi_d;
                    for (int unsigned g = 0; g < 2; g++) begin
                        for (int unsigned c = 0; c < MAX_CH; c++) begin
                            bus.part2_3_length[g][c]        <= rec_d[g][c].p23;
                            bus.big_values[g][c]            <= rec_d[g][c].bv;
                            bus.global_gain[g][c]           <= rec_d[g][c].gg;
                            bus.scalefac_compress[g][c]     <= rec_d[g][c].sfc;
                            bus.window_switching_flag[g][c] <= rec_d[g][c].wsf;
                            bus.block_type[g][c]            <= rec_d[g][c].bt;
                            bus.mixed_block_flag[g][c]      <= rec_d[g][c].mixed;
                            bus.table_select[g][c]          <= rec_d[g][c].ts;
                            bus.subblock_gain[g][c]         <= rec_d[g][c].sbg;
                            bus.region0_count[g][c]         <= rec_d[g][c].r0;
                            bus.region1_count[g][c]         <= rec_d[g][c].r1;
                            bus.preflag[g][c]               <= rec_d[g][c].pre;
                            bus.scalefac_scale[g][c]        <= rec_d[g][c].sfs;
                            bus.count1table_select[g][c]    <= rec_d[g][c].c1t;
                        end
                    end
                end else begin
                    state <= COLLECT;
                    cnt   <= cur_idx + 6'd1;
                end
            end else if (bus.frame_start) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == DECODE) begin
                state <= IDLE;
            end
        end
    end

`ifdef SIDE_INFO_CHECK_EN
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = 1'b0;
        for (int unsigned g = 0; g < 2; g++) begin
            for (int unsigned c = 0; c < MAX_CH; c++) begin
                if ((rec_d[g][c].bv > 9'd288) || (rec_d[g][c].wsf && (rec_d[g][c].bt == 2'd0))) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (last) begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
